second_game_logic: RTL
======================

// Module: second_game_logic
// PURPOSE
// Game-state engine for the second game, directly upstream of second_game_graphics. Holds a
// vertically scrolling obstacle field (ring of LFSR-generated cell rows), the player square
// position and the IDLE/RUN/OVER state machine. Answers per-pixel obstacle queries with zero
// latency for the graphics stage, detects player/obstacle overlap during the scan and counts score.
// PARAMETERS
// SCREEN_WIDTH   400     game area width, px (XW = $clog2(SCREEN_WIDTH))
// SCREEN_HEIGHT  600     game area height, px (YW = $clog2(SCREEN_HEIGHT))
// PLAYER_SIZE    20      player half-size, px; the box spans centre +/- PLAYER_SIZE
// PLAYER_Y       540     fixed player centre y
// PLAYER_STEP    4       px moved per frame tick while a direction button is held
// CELL_LOG2      5       cell size = 2**CELL_LOG2 px; COLS = ceil(W/cell) (8..16), ROWS = ceil(H/cell)+1
// SCROLL_SPEED   2       px scrolled per frame tick, 1..cell-1
// MAX_SPEED      8       speed ceiling, used only with SECOND_GAME_SPEEDUP_EN
// LFSR_SEED      16'hACE1 reset value of 16-bit Galois LFSR (taps 16,14,13,11), nonzero
// PORTS
// i_clk          in   1    system clock
// i_rst_n        in   1    asynchronous active-low reset
// i_frame_tick   in   1    1-cycle pulse once per frame, during vertical blanking
// i_start        in   1    start/restart request, level (sampled every cycle)
// i_btn_left     in   1    move left, level
// i_btn_right    in   1    move right, level
// i_disp_enbl    in   1    display enable for the current pixel
// i_field_enbl   in   1    current pixel lies inside the game area
// i_screen_x     in   XW   pixel x within game area (from graphics o_screen_x)
// i_screen_y     in   YW   pixel y within game area (from graphics o_screen_y)
// o_is_obstacle  out  1    current pixel is inside an obstacle cell (combinational)
// o_player_x     out  XW   player centre x
// o_player_y     out  YW   player centre y (= PLAYER_Y)
// o_running      out  1    state == RUN
// o_game_over    out  1    state == OVER
// o_score        out  16   rows scrolled past in RUN, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset: state IDLE, all rows 0, head 0, offset 0, player_x = SCREEN_WIDTH/2, score 0,
//   hit flag 0, LFSR = LFSR_SEED, speed = SCROLL_SPEED; o_running = o_game_over = 0.
// - FSM: IDLE -i_start-> RUN; RUN -(i_frame_tick & (hit_q | hit_now))-> OVER; OVER -i_start-> IDLE.
//   i_start is ignored in RUN. OVER->IDLE re-applies reset values except the LFSR (keeps running).
// - LFSR steps every clock in all states.
// - Lookup (0 cycles): ys = i_screen_y + cell - offset; r = ys >> CELL_LOG2; c = i_screen_x >> CELL_LOG2;
//   o_is_obstacle = rows[(head + r) mod ROWS][c]; forced 0 if x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT.
// - Scroll, RUN only, on i_frame_tick: s = offset + speed; if s < cell, offset = s; else
//   offset = s - cell, head = (head - 1) mod ROWS, rows[new head] = new row, score += 1 (saturating).
// - New row: row counter even -> all zeros; odd -> LFSR[COLS-1:0] with gap g = LFSR[15:12],
//   g' = g<COLS ? g : g-COLS; cells g', g'+1, g'+2 (clipped at COLS-1) forced clear.
// - Player, RUN only, on i_frame_tick: left XOR right moves by PLAYER_STEP; both or none: hold;
//   clamp to [PLAYER_SIZE, SCREEN_WIDTH-1-PLAYER_SIZE].
// - Collision: hit_now = i_disp_enbl & i_field_enbl & o_is_obstacle & pixel inside player box
//   (inclusive bounds); hit_q sets on hit_now; on i_frame_tick FSM uses hit_q|hit_now, then
//   hit_q clears (a hit coincident with the tick is counted in the current frame).
// - IDLE and OVER: field, offset, player and score frozen; lookup stays live.
// CONFIGURATION
// SECOND_GAME_SPEEDUP_EN defined: speed += 1 each time score[3:0] wraps to 0, capped at MAX_SPEED;
//   reset to SCROLL_SPEED on reset and OVER->IDLE. Undefined: speed constant SCROLL_SPEED.
// TESTING
// 1. Reset, idle 3 frames -> player_x=200, o_is_obstacle=0 everywhere, score 0, o_running=0.
// 2. i_start, 16 ticks at speed 2 -> one advance: offset 0, score 1, head=ROWS-1, new row all 0.
// 3. RUN, right held 100 ticks -> player_x clamps at 379; both buttons held -> no change.
// 4. Preload obstacle under player, scan frame then tick -> o_game_over=1 next cycle; i_start -> IDLE, score 0.
// 5. Hit on same cycle as i_frame_tick -> OVER on that tick; hit_q cleared.
// 6. SPEEDUP_EN: 16 advances -> speed 3; speed never exceeds 8; without macro speed stays 2.

Source files
------------

// File: rtl/second_game_logic.sv
// Game-state engine for the second game: scrolling obstacle field, player and IDLE/RUN/OVER FSM.
// Define SECOND_GAME_SPEEDUP_EN to raise scroll speed every 16 rows, capped at MAX_SPEED.
module second_game_logic #(
    parameter int          SCREEN_WIDTH  = 400,
    parameter int          SCREEN_HEIGHT = 600,
    parameter int          PLAYER_SIZE   = 20,
    parameter int          PLAYER_Y      = 540,
    parameter int          PLAYER_STEP   = 4,
    parameter int          CELL_LOG2     = 5,
    parameter int          SCROLL_SPEED  = 2,
    parameter int          MAX_SPEED     = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    localparam int         XW            = $clog2(SCREEN_WIDTH),
    localparam int         YW            = $clog2(SCREEN_HEIGHT)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_frame_tick,
    input  logic          i_start,
    input  logic          i_btn_left,
    input  logic          i_btn_right,
    input  logic          i_disp_enbl,
    input  logic          i_field_enbl,
    input  logic [XW-1:0] i_screen_x,
    input  logic [YW-1:0] i_screen_y,
    output logic          o_is_obstacle,
    output logic [XW-1:0] o_player_x,
    output logic [YW-1:0] o_player_y,
    output logic          o_running,
    output logic          o_game_over,
    output logic [15:0]   o_score
);
    localparam int CELL = 1 << CELL_LOG2;
    localparam int COLS = (SCREEN_WIDTH + CELL - 1) / CELL;
    localparam int ROWS = (SCREEN_HEIGHT + CELL - 1) / CELL + 1;
    localparam int HW   = $clog2(ROWS);
    localparam int RW   = YW + 1 - CELL_LOG2;
    localparam int SW   = ((RW > HW) ? RW : HW) + 1;
    localparam int OW   = CELL_LOG2;
    localparam int SPW  =
        $clog2(((MAX_SPEED > SCROLL_SPEED) ? MAX_SPEED : SCROLL_SPEED) + 1);

    localparam logic [XW-1:0]  X_END     = XW'(SCREEN_WIDTH);
    localparam logic [YW-1:0]  Y_END     = YW'(SCREEN_HEIGHT);
    localparam logic [XW-1:0]  X_MID     = XW'(SCREEN_WIDTH / 2);
    localparam logic [XW:0]    P_SZ      = (XW+1)'(PLAYER_SIZE);
    localparam logic [XW:0]    X_HI      = (XW+1)'(SCREEN_WIDTH - 1 - PLAYER_SIZE);
    localparam logic [XW:0]    STEP      = (XW+1)'(PLAYER_STEP);
    localparam logic [YW-1:0]  Y_LO      = YW'(PLAYER_Y - PLAYER_SIZE);
    localparam logic [YW-1:0]  Y_HI      = YW'(PLAYER_Y + PLAYER_SIZE);
    localparam logic [SPW-1:0] SPD0      = SPW'(SCROLL_SPEED);
    localparam logic [HW-1:0]  HEAD_LAST = HW'(ROWS - 1);
    localparam logic [SW-1:0]  ROWS_S    = SW'(ROWS);
    localparam logic [4:0]     COLS_G    = 5'(COLS);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [15:0]                lfsr;
    logic [ROWS-1:0][COLS-1:0]  rows;
    logic [HW-1:0]              head;
    logic [HW-1:0]              head_nxt;
    logic [OW-1:0]              offset;
    logic [SPW-1:0]             speed;
    logic [OW:0]                sum;
    logic [XW-1:0]              player_x;
    logic [XW-1:0]              px_nxt;
    logic [XW:0]                px_w;
    logic [15:0]                score;
    logic [15:0]                score_inc;
    logic                       row_odd;
    logic                       hit_q;
    logic                       hit_now;
    logic                       run_tick;
    logic                       advance;
    logic                       restart;
    logic [YW:0]                ys;
    logic [SW-1:0]              row_sum;
    logic [SW-1:0]              row_idx;
    logic [XW-CELL_LOG2-1:0]    col_idx;
    logic                       in_range;
    logic                       x_in;
    logic                       y_in;
    logic [4:0]                 gap;
    logic [COLS-1:0]            mask;
    logic [COLS-1:0]            new_row;

    assign run_tick  = (state == RUN) && i_frame_tick;
    assign restart   = (state == OVER) && i_start;
    assign sum       = {1'b0, offset} + (OW+1)'(speed);
    assign advance   = run_tick && sum[OW];
    assign score_inc = score + 16'd1;
    assign head_nxt  = (head == '0) ? HEAD_LAST : head - HW'(1);

    // Row 0 of the lookup is the cell just above the visible top edge
    always_comb begin
        ys       = {1'b0, i_screen_y} + (YW+1)'(CELL) - (YW+1)'(offset);
        row_sum  = SW'(ys[YW:CELL_LOG2]) + SW'(head);
        row_idx  = (row_sum >= ROWS_S) ? row_sum - ROWS_S : row_sum;
        col_idx  = i_screen_x[XW-1:CELL_LOG2];
        in_range = (i_screen_x < X_END) && (i_screen_y < Y_END);
        o_is_obstacle = 1'b0;
        if (in_range) o_is_obstacle = rows[row_idx[HW-1:0]][col_idx];
    end

    always_comb begin
        x_in = ({1'b0, i_screen_x} + P_SZ >= {1'b0, player_x})
            && ({1'b0, i_screen_x} <= {1'b0, player_x} + P_SZ);
        y_in = (i_screen_y >= Y_LO) && (i_screen_y <= Y_HI);
        hit_now = i_disp_enbl && i_field_enbl && o_is_obstacle && x_in && y_in;
    end

    always_comb begin
        gap = {1'b0, lfsr[15:12]};
        if (gap >= COLS_G) gap = gap - COLS_G;
        mask = '0;
        for (int i = 0; i < COLS; i++) begin
            if (i >= int'(gap) && i <= int'(gap) + 2) mask[i] = 1'b1;
        end
        new_row = row_odd ? (lfsr[COLS-1:0] & ~mask) : '0;
    end

    always_comb begin
        px_w   = {1'b0, player_x};
        px_nxt = player_x;
        if (i_btn_left && !i_btn_right) begin
            px_nxt = (px_w >= P_SZ + STEP) ? XW'(px_w - STEP) : XW'(P_SZ);
        end else if (i_btn_right && !i_btn_left) begin
            px_nxt = (px_w + STEP > X_HI) ? XW'(X_HI) : XW'(px_w + STEP);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (i_start) state_nxt = RUN;
            RUN:     if (i_frame_tick && (hit_q || hit_now)) state_nxt = OVER;
            OVER:    if (i_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // The LFSR free-runs through restarts so each game gets a new field
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) lfsr <= LFSR_SEED;
        else          lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)          hit_q <= 1'b0;
        else if (restart)      hit_q <= 1'b0;
        else if (i_frame_tick) hit_q <= 1'b0;
        else if (hit_now)      hit_q <= 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rows     <= '0;
            head     <= '0;
            offset   <= '0;
            player_x <= X_MID;
            score    <= '0;
            row_odd  <= 1'b0;
        end else if (restart) begin
            rows     <= '0;
            head     <= '0;
            offset   <= '0;
            player_x <= X_MID;
            score    <= '0;
            row_odd  <= 1'b0;
        end else if (run_tick) begin
            offset   <= sum[OW-1:0];
            player_x <= px_nxt;
            if (advance) begin
                head           <= head_nxt;
                rows[head_nxt] <= new_row;
                row_odd        <= ~row_odd;
                if (score != 16'hFFFF) score <= score_inc;
            end
        end
    end

`ifdef SECOND_GAME_SPEEDUP_EN
    localparam logic [SPW-1:0] SPD_MAX = SPW'(MAX_SPEED);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            speed <= SPD0;
        end else if (restart) begin
            speed <= SPD0;
        end else if (advance && score != 16'hFFFF
                     && score_inc[3:0] == 4'd0 && speed < SPD_MAX) begin
            speed <= speed + SPW'(1);
        end
    end
`else
    assign speed = SPD0;
`endif

    assign o_player_x  = player_x;
    assign o_player_y  = YW'(PLAYER_Y);
    assign o_running   = (state == RUN);
    assign o_game_over = (state == OVER);
    assign o_score     = score;

endmodule
